mem_dma_arbiter: RTL and testbench
==================================

MEM_DMA_ARBITER -- requirements
Module: mem_dma_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning depth of the DMA write-back buffer (power of two, >=4).
REQ-002 SHALL have clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have cpu_ren / cpu_raddr  input  1/16  CPU read request on mem read port 1.
REQ-005 SHALL have cpu_wen / cpu_waddr / cpu_wdata  input  1/16/16  CPU write request.
REQ-006 SHALL have dma_start  input  1  one-cycle start pulse; dma_fill  input  1  0=copy, 1=fill.
REQ-007 SHALL have dma_src / dma_dst / dma_len / dma_value  input  16 each  source, destination, word count, fill word; sampled only on accepted start.
REQ-008 SHALL have dma_busy  output  1, dma_done  output  1 (one-cycle pulse), dma_err  output  1 (one-cycle pulse, coincident with dma_done).
REQ-009 SHALL have mem_ren / mem_raddr  output  1/16  and mem_wen / mem_waddr / mem_wdata  output  1/16/16  to mem read port 1 and write port.
REQ-010 SHALL have mem_rdata  input  16  mem read port 1 data, valid exactly 2 cycles after the address is presented.

Function
REQ-011 CPU SHALL have absolute priority: cpu_ren=1 drives mem_raddr=cpu_raddr, mem_ren=1 combinationally in the same cycle; likewise cpu_wen for the write port.
REQ-012 DMA SHALL use the read port only in cycles with cpu_ren=0 and the write port only in cycles with cpu_wen=0; CPU requests are never stalled.
REQ-013 States: IDLE, COPY, FILL, DRAIN; dma_busy=1 in all but IDLE.
REQ-014 IDLE: dma_start=1 latches config; dma_len=0 -> dma_done next cycle, no memory access, stay IDLE; else COPY (dma_fill=0) or FILL (dma_fill=1).
REQ-015 Copy error check: if dma_fill=0 and (dma_src + dma_len) > 0xF000 in 17-bit arithmetic, no access is made and dma_done+dma_err pulse next cycle (protects PS2_REG read side effect and IO region).
REQ-016 dma_start while busy SHALL be ignored and not queued.
REQ-017 COPY: issue read of src+i (i=0..len-1) when read port free and (in_flight + fifo_count) < FIFO_DEPTH; in_flight tracked by 2-stage valid shift register.
REQ-018 Read data arriving at mem_rdata SHALL be written to dst+j in the same cycle if write port free and FIFO empty, else pushed to FIFO; FIFO drains in order one word per free write cycle.
REQ-019 When all len reads are issued, COPY -> DRAIN; DRAIN -> IDLE when in_flight=0 and FIFO empty and last write done, with dma_done pulsed in the cycle after the last write.
REQ-020 FILL: write dma_value to dst+i each cycle cpu_wen=0; after len writes, done pulse next cycle, -> IDLE.
REQ-021 Address arithmetic SHALL be 16-bit wrap-around (dst 0xFFFF+1 -> 0x0000); writes at/above 0xF000 are issued and counted (mem ignores them).
REQ-022 mem_wen from DMA and mem_ren from DMA SHALL never assert for more than len accesses per transfer.
REQ-023 When neither CPU nor DMA use a port, mem_ren/mem_wen SHALL be 0 and address/data outputs 0.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, dma_busy=0, dma_done=0, dma_err=0, FIFO empty, in_flight cleared, all counters 0.
REQ-025 Reset mid-transfer SHALL abort without dma_done; read data returning after reset release is discarded.
REQ-026 CPU pass-through SHALL remain combinational and functional during reset.

Structure
REQ-027 State encoding, IO_START (0xF000) and memory-map constants SHALL live in a shared package used with mem.
REQ-028 The write-back buffer SHALL be one sub-module, sync_fifo (push, pop, full, empty, count).

Verification
REQ-029 Fill: dst=0xE000, len=8, value=0x00AB, CPU idle -> 8 consecutive writes 0xE000..0xE007, dma_done 1 cycle after last.
REQ-030 Copy: src=0x0100 preloaded 1..16, dst=0xE000, len=16, CPU idle -> 0xE000..0xE00F = 1..16, in order, done once.
REQ-031 Contention: copy len=32 with cpu_wen random 50% -> CPU writes unaltered, FIFO never overflows, destination correct.
REQ-032 Error: copy src=0xEFFF, len=2 -> no mem_ren, dma_done=dma_err=1 next cycle; src=0xEFFF, len=1 -> normal.
REQ-033 Wrap: fill dst=0xFFFE, len=4 -> writes 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-034 Reset: rst_n low after 5 words of 16-word copy -> busy=0 immediately, no done, no further DMA accesses.

Source files
------------

// File: rtl/mem_dma_arbiter_pkg.sv
// Shared types and memory-map constants for the DMA arbiter and the memory it fronts.
package mem_dma_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // Start of the IO region (PS2_REG and peripherals); copy reads must stay below it.
    localparam logic [ADDR_W-1:0] IO_START = 16'hF000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } dma_state_t;

    function automatic logic copy_range_bad(input logic [ADDR_W-1:0] src,
                                            input logic [ADDR_W-1:0] len);
        return ({1'b0, src} + {1'b0, len}) > {1'b0, IO_START};
    endfunction

endpackage

// File: rtl/mem_dma_arbiter_sync_fifo.sv
// Small synchronous FIFO used as the DMA write-back buffer.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rp];

    always_ff @(posedge clk) begin
        if (do_push) store[wp] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mem_dma_arbiter.sv
// Memory port arbiter: CPU has absolute priority, a copy/fill DMA engine uses idle port cycles.
module mem_dma_arbiter
    import mem_dma_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_ren,
    input  logic [ADDR_W-1:0] cpu_raddr,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dma_start,
    input  logic              dma_fill,
    input  logic [ADDR_W-1:0] dma_src,
    input  logic [ADDR_W-1:0] dma_dst,
    input  logic [ADDR_W-1:0] dma_len,
    input  logic [DATA_W-1:0] dma_value,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              dma_err,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    dma_state_t        state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] value;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic [1:0]        vld;

    logic              f_push;
    logic              f_pop;
    logic [DATA_W-1:0] f_dout;
    logic              f_full;
    logic              f_empty;
    logic [CW-1:0]     f_count;

    logic [CW-1:0]     in_flight;
    logic              copy_phase;
    logic              dma_rd;
    logic              dma_wr;

    assign dma_busy   = (state != ST_IDLE);
    assign copy_phase = (state == ST_COPY) || (state == ST_DRAIN);
    assign in_flight  = CW'(vld[0]) + CW'(vld[1]);

    // A read is only issued if its data is guaranteed a FIFO slot on arrival.
    assign dma_rd = (state == ST_COPY) && !cpu_ren && !f_full
                    && ((in_flight + f_count) < CW'(FIFO_DEPTH));
    assign dma_wr = !cpu_wen && ((state == ST_FILL)
                    || (copy_phase && (!f_empty || vld[1])));

    // Arriving data bypasses the FIFO only when it is empty and the write port is free.
    assign f_pop  = copy_phase && !cpu_wen && !f_empty;
    assign f_push = vld[1] && (cpu_wen || !f_empty);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (f_push),
        .pop   (f_pop),
        .din   (mem_rdata),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    always_comb begin
        mem_ren   = 1'b0;
        mem_raddr = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (cpu_ren) begin
            mem_ren   = 1'b1;
            mem_raddr = cpu_raddr;
        end else if (dma_rd) begin
            mem_ren   = 1'b1;
            mem_raddr = src + rd_cnt;
        end
        if (cpu_wen) begin
            mem_wen   = 1'b1;
            mem_waddr = cpu_waddr;
            mem_wdata = cpu_wdata;
        end else if (dma_wr) begin
            mem_wen   = 1'b1;
            mem_waddr = dst + wr_cnt;
            if (state == ST_FILL)  mem_wdata = value;
            else if (f_empty)      mem_wdata = mem_rdata;
            else                   mem_wdata = f_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            value    <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            vld      <= '0;
            dma_done <= 1'b0;
            dma_err  <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            dma_err  <= 1'b0;
            vld      <= {vld[0], dma_rd};
            if (dma_rd) rd_cnt <= rd_cnt + 16'd1;
            if (dma_wr) wr_cnt <= wr_cnt + 16'd1;
            unique case (state)
                ST_IDLE: begin
                    if (dma_start) begin
                        src    <= dma_src;
                        dst    <= dma_dst;
                        len    <= dma_len;
                        value  <= dma_value;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                        if (dma_len == '0) begin
                            dma_done <= 1'b1;
                        end else if (!dma_fill && copy_range_bad(dma_src, dma_len)) begin
                            dma_done <= 1'b1;
                            dma_err  <= 1'b1;
                        end else begin
                            state <= dma_fill ? ST_FILL : ST_COPY;
                        end
                    end
                end
                ST_COPY: begin
                    if (dma_rd && (rd_cnt + 16'd1 == len)) state <= ST_DRAIN;
                end
                ST_FILL, ST_DRAIN: begin
                    if (dma_wr && (wr_cnt + 16'd1 == len)) begin
                        state    <= ST_IDLE;
                        dma_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dma_arbiter.sv
// Directed bench for mem_dma_arbiter with a 2-cycle-latency memory model and a DMA write logger.
module tb_mem_dma_arbiter;
    logic        clk;
    logic        rst_n;
    logic        cpu_ren;
    logic [15:0] cpu_raddr;
    logic        cpu_wen;
    logic [15:0] cpu_waddr;
    logic [15:0] cpu_wdata;
    logic        dma_start;
    logic        dma_fill;
    logic [15:0] dma_src;
    logic [15:0] dma_dst;
    logic [15:0] dma_len;
    logic [15:0] dma_value;
    logic        dma_busy;
    logic        dma_done;
    logic        dma_err;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic        mem_wen;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_cmp;
    int n_fail;

    logic [15:0] mem [0:65535];
    logic [15:0] ra1;
    logic [15:0] ra2;

    logic [15:0] wq_a [$];
    logic [15:0] wq_d [$];
    int          wq_c [$];
    int          dma_reads;
    int          done_cnt;
    int          err_cnt;
    int          done_cyc;
    int          cpu_bad;
    int          idle_bad;
    int          cyc;

    mem_dma_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_ren   (cpu_ren),
        .cpu_raddr (cpu_raddr),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .dma_start (dma_start),
        .dma_fill  (dma_fill),
        .dma_src   (dma_src),
        .dma_dst   (dma_dst),
        .dma_len   (dma_len),
        .dma_value (dma_value),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done),
        .dma_err   (dma_err),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: read data valid two cycles after the address; IO region ignores writes.
    always @(posedge clk) begin
        ra1 <= mem_raddr;
        ra2 <= ra1;
        if (mem_wen === 1'b1 && mem_waddr < 16'hF000) mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[ra2];

    always @(negedge clk) begin
        if (mem_ren === 1'b1 && !cpu_ren) dma_reads++;
        if (mem_wen === 1'b1 && !cpu_wen) begin
            wq_a.push_back(mem_waddr);
            wq_d.push_back(mem_wdata);
            wq_c.push_back(cyc);
        end
        if (cpu_ren && (mem_ren !== 1'b1 || mem_raddr !== cpu_raddr)) cpu_bad++;
        if (cpu_wen && (mem_wen !== 1'b1 || mem_waddr !== cpu_waddr || mem_wdata !== cpu_wdata)) cpu_bad++;
        if (mem_ren !== 1'b1 && mem_raddr !== 16'h0) idle_bad++;
        if (mem_wen !== 1'b1 && (mem_waddr !== 16'h0 || mem_wdata !== 16'h0)) idle_bad++;
        if (dma_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (dma_err === 1'b1) err_cnt++;
        cyc++;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        wq_a.delete();
        wq_d.delete();
        wq_c.delete();
        dma_reads = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        done_cyc  = -1;
    endtask

    task automatic start_dma(input logic fill, input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] len, input logic [15:0] value);
        step;
        dma_fill  = fill;
        dma_src   = src;
        dma_dst   = dst;
        dma_len   = len;
        dma_value = value;
        dma_start = 1'b1;
        step;
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            #1;
            if (dma_done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic check_writes(input string name, input logic [15:0] base, input int n,
                                input logic [15:0] data0, input logic incr, input logic consec);
        logic [15:0] ea;
        logic [15:0] ed;
        logic [15:0] aa;
        logic [15:0] ad;
        int          ac;
        n_cmp++;
        if (wq_a.size() != n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, wq_a.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            ea = base + 16'(i);
            ed = incr ? data0 + 16'(i) : data0;
            aa = (i < wq_a.size()) ? wq_a[i] : 16'hxxxx;
            ad = (i < wq_d.size()) ? wq_d[i] : 16'hxxxx;
            ac = (i < wq_c.size()) ? wq_c[i] - wq_c[0] : -1;
            n_cmp++;
            if (aa !== ea || ad !== ed || (consec && ac != i)) begin
                n_fail++;
                $display("FAIL %s_word[%0d]: got addr=%h data=%h slot=%0d, expected addr=%h data=%h slot=%0d",
                         name, i, aa, ad, ac, ea, ed, i);
            end
        end
    endtask

    task automatic check_done_after_last(input string name);
        int last;
        last = (wq_c.size() > 0) ? wq_c[wq_c.size()-1] : -100;
        n_cmp++;
        if (done_cyc != last + 1 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s_done: got done at %0d (count %0d), expected at %0d (count 1)",
                     name, done_cyc, done_cnt, last + 1);
        end
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if (dma_busy !== 1'b0 || dma_done !== 1'b0 || dma_err !== 1'b0 ||
            mem_ren !== 1'b0 || mem_wen !== 1'b0 || mem_raddr !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b ren=%b wen=%b raddr=%h, expected all 0",
                     dma_busy, dma_done, dma_err, mem_ren, mem_wen, mem_raddr);
        end
        cpu_ren = 1'b1; cpu_raddr = 16'h1234;
        cpu_wen = 1'b1; cpu_waddr = 16'h0300; cpu_wdata = 16'hBEEF;
        #1;
        n_cmp++;
        if (mem_ren !== 1'b1 || mem_raddr !== 16'h1234 || mem_wen !== 1'b1 ||
            mem_waddr !== 16'h0300 || mem_wdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL reset_passthru: got ren=%b raddr=%h wen=%b waddr=%h wdata=%h, expected 1 1234 1 0300 beef",
                     mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata);
        end
        cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step;
    endtask

    task automatic test_fill;
        bit seen;
        clear_logs;
        start_dma(1'b1, 16'h0000, 16'hE000, 16'd8, 16'h00AB);
        wait_done(50, seen);
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL fill_timeout: got no dma_done, expected one"); end
        repeat (3) step;
        check_writes("fill", 16'hE000, 8, 16'h00AB, 1'b0, 1'b1);
        check_done_after_last("fill");
        n_cmp++;
        if (dma_reads != 0 || err_cnt != 0 || dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_misc: got reads=%0d err=%0d busy=%b, expected 0 0 0", dma_reads, err_cnt, dma_busy);
        end
    endtask

    task automatic test_copy;
        bit seen;
        int bad;
        clear_logs;
        start_dma(1'b0, 16'h0100, 16'hE000, 16'd16, 16'h0000);
        wait_done(100, seen);
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL copy_timeout: got no dma_done, expected one"); end
        repeat (3) step;
        check_writes("copy", 16'hE000, 16, 16'h0001, 1'b1, 1'b0);
        check_done_after_last("copy");
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[16'hE000 + i] !== 16'(i + 1)) bad++;
        n_cmp++;
        if (dma_reads != 16 || bad != 0) begin
            n_fail++;
            $display("FAIL copy_mem: got reads=%0d bad_words=%0d, expected 16 0", dma_reads, bad);
        end
    endtask

    task automatic test_zero_len;
        clear_logs;
        start_dma(1'b1, 16'h0000, 16'hE400, 16'd0, 16'h1111);
        @(negedge clk);
        #1;
        n_cmp++;
        if (dma_done !== 1'b1 || dma_err !== 1'b0 || dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len: got done=%b err=%b busy=%b, expected 1 0 0", dma_done, dma_err, dma_busy);
        end
        repeat (3) step;
        n_cmp++;
        if (wq_a.size() != 0 || dma_reads != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL zero_len_access: got writes=%0d reads=%0d dones=%0d, expected 0 0 1",
                     wq_a.size(), dma_reads, done_cnt);
        end
    endtask

    task automatic test_error;
        bit seen;
        clear_logs;
        start_dma(1'b0, 16'hEFFF, 16'hE100, 16'd2, 16'h0000);
        @(negedge clk);
        #1;
        n_cmp++;
        if (dma_done !== 1'b1 || dma_err !== 1'b1 || dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: got done=%b err=%b busy=%b, expected 1 1 0", dma_done, dma_err, dma_busy);
        end
        repeat (4) step;
        n_cmp++;
        if (dma_reads != 0 || wq_a.size() != 0 || err_cnt != 1 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL err_access: got reads=%0d writes=%0d errs=%0d dones=%0d, expected 0 0 1 1",
                     dma_reads, wq_a.size(), err_cnt, done_cnt);
        end
        clear_logs;
        start_dma(1'b0, 16'hEFFF, 16'hE100, 16'd1, 16'h0000);
        wait_done(50, seen);
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL edge_timeout: got no dma_done, expected one"); end
        repeat (3) step;
        check_writes("edge", 16'hE100, 1, 16'h5A5A, 1'b0, 1'b0);
        n_cmp++;
        if (dma_reads != 1 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL edge_misc: got reads=%0d errs=%0d, expected 1 0", dma_reads, err_cnt);
        end
    endtask

    task automatic test_wrap;
        bit seen;
        clear_logs;
        start_dma(1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h0C0C);
        wait_done(50, seen);
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL wrap_timeout: got no dma_done, expected one"); end
        repeat (3) step;
        check_writes("wrap", 16'hFFFE, 4, 16'h0C0C, 1'b0, 1'b1);
        n_cmp++;
        if (mem[16'h0000] !== 16'h0C0C || mem[16'h0001] !== 16'h0C0C) begin
            n_fail++;
            $display("FAIL wrap_mem: got %h %h, expected 0c0c 0c0c", mem[16'h0000], mem[16'h0001]);
        end
    endtask

    task automatic test_contention;
        bit seen;
        int bad;
        clear_logs;
        start_dma(1'b0, 16'h0200, 16'hE300, 16'd32, 16'h0000);
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            cpu_wen   = 1'($urandom_range(0, 1));
            cpu_waddr = 16'h0400 + 16'(k);
            cpu_wdata = 16'($urandom);
            cpu_ren   = 1'($urandom_range(0, 1));
            cpu_raddr = 16'($urandom_range(0, 16'h0FFF));
            @(negedge clk);
            #1;
            if (dma_done === 1'b1) seen = 1'b1;
            step;
        end
        cpu_wen = 1'b0; cpu_ren = 1'b0; cpu_waddr = '0; cpu_wdata = '0; cpu_raddr = '0;
        n_cmp++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL cont_timeout: got no dma_done, expected one"); end
        repeat (3) step;
        check_writes("cont", 16'hE300, 32, 16'h3000, 1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[16'hE300 + i] !== 16'h3000 + 16'(i)) bad++;
        n_cmp++;
        if (dma_reads != 32 || bad != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL cont_mem: got reads=%0d bad_words=%0d dones=%0d, expected 32 0 1",
                     dma_reads, bad, done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int n_before;
        int rd_before;
        clear_logs;
        start_dma(1'b0, 16'h0100, 16'hE200, 16'd16, 16'h0000);
        for (int i = 0; i < 200 && wq_a.size() < 5; i++) begin
            @(negedge clk);
            #2;
        end
        n_cmp++;
        if (wq_a.size() < 5) begin
            n_fail++;
            $display("FAIL rst_mid_timeout: got %0d writes, expected at least 5", wq_a.size());
        end
        rst_n = 1'b0;
        #1;
        n_before  = wq_a.size();
        rd_before = dma_reads;
        n_cmp++;
        if (dma_busy !== 1'b0 || dma_done !== 1'b0 || dma_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got busy=%b done=%b err=%b, expected 0 0 0", dma_busy, dma_done, dma_err);
        end
        repeat (3) step;
        rst_n = 1'b1;
        repeat (20) step;
        n_cmp++;
        if (wq_a.size() != n_before || dma_reads != rd_before || done_cnt != 0 || dma_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: got writes=%0d reads=%0d dones=%0d busy=%b, expected %0d %0d 0 0",
                     wq_a.size(), dma_reads, done_cnt, dma_busy, n_before, rd_before);
        end
    endtask

    task automatic test_port_rules;
        n_cmp++;
        if (cpu_bad != 0) begin
            n_fail++;
            $display("FAIL cpu_priority: got %0d altered CPU cycles, expected 0", cpu_bad);
        end
        n_cmp++;
        if (idle_bad != 0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %0d nonzero idle address/data cycles, expected 0", idle_bad);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_ren = 1'b0; cpu_raddr = '0; cpu_wen = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
        dma_start = 1'b0; dma_fill = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0; dma_value = '0;
        n_cmp = 0; n_fail = 0; cpu_bad = 0; idle_bad = 0; cyc = 0;
        ra1 = '0; ra2 = '0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'(i + 1);
        for (int i = 0; i < 32; i++) mem[16'h0200 + i] = 16'h3000 + 16'(i);
        mem[16'hEFFF] = 16'h5A5A;
        clear_logs;

        test_reset;
        test_fill;
        test_copy;
        test_zero_len;
        test_error;
        test_wrap;
        test_contention;
        test_reset_mid;
        test_port_rules;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
